// File: rtl/acc_exec_stage.sv
// Execute stage for the accumulator processor: one decoded instruction per handshake,
// multi-cycle shift-add multiply, scratch register file and vectored interrupt entry/return.
module acc_exec_stage #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int RF_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    StageRegInstr_out,
    input  logic [2:0]    StageRegAddrMode_out,
    input  logic [DW-1:0] StageRegData_out,
    input  logic [AW-1:0] StageRegPCtr_out,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] InteruptAdrReg,
    input  logic          int_req,
    output logic [DW-1:0] ACCout,
    output logic          coutRegout,
    output logic          zeroRegout,
    output logic          overflowRegout,
    output logic [AW-1:0] NextPctr,
    output logic          StageComplete,
    output logic          int_ack
);
    localparam int IW = $clog2(RF_DEPTH);
    localparam int CW = $clog2(DW) + 1;

    localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_AND = 5'h03, OP_OR  = 5'h04,
                           OP_XOR = 5'h05, OP_SHL = 5'h06, OP_SHR = 5'h07, OP_LDA = 5'h08,
                           OP_STA = 5'h09, OP_JMP = 5'h0A, OP_JZ  = 5'h0B, OP_JC  = 5'h0C,
                           OP_MUL = 5'h0D, OP_RETI = 5'h0E, OP_EI = 5'h0F, OP_DI  = 5'h10;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [2:0]      mode_q, mode_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic            cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [AW-1:0]   npc_q, npc_d, saved_pc_q, saved_pc_d, pend_npc_q, pend_npc_d;
    logic            int_en_q, int_en_d, int_ack_q, int_ack_d, pend_ack_q, pend_ack_d;
    logic [2*DW-1:0] mul_a_q, mul_a_d, prod_q, prod_d;
    logic [DW-1:0]   mul_b_q, mul_b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rf_q [RF_DEPTH];

    logic            rf_we, take_int, wr, res_c, res_v;
    logic [IW-1:0]   rf_idx;
    logic [DW-1:0]   operand, res;
    logic [DW:0]     sum, diff;
    logic [AW-1:0]   npc_calc;
    logic [2*DW-1:0] mul_sum;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mode_d     = mode_q;
        data_d     = data_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        cout_d     = cout_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        npc_d      = npc_q;
        saved_pc_d = saved_pc_q;
        pend_npc_d = pend_npc_q;
        pend_ack_d = pend_ack_q;
        int_en_d   = int_en_q;
        int_ack_d  = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        prod_d     = prod_q;
        cnt_d      = cnt_q;
        rf_we      = 1'b0;
        wr         = 1'b0;
        res        = '0;
        res_c      = 1'b0;
        res_v      = 1'b0;
        rf_idx     = data_q[IW-1:0];
        operand    = (mode_q == 3'b001) ? rf_q[rf_idx] : data_q;
        sum        = {1'b0, acc_q} + {1'b0, operand};
        diff       = {1'b0, acc_q} - {1'b0, operand};
        npc_calc   = pc_q + AW'(1);
        take_int   = int_req && int_en_q && (op_q != OP_RETI);
        mul_sum    = prod_q + (mul_b_q[0] ? mul_a_q : '0);

        unique case (state_q)
            IDLE: if (in_valid) begin
                op_d    = StageRegInstr_out;
                mode_d  = StageRegAddrMode_out;
                data_d  = StageRegData_out;
                pc_d    = StageRegPCtr_out;
                state_d = EXEC;
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        wr = 1'b1; res = sum[DW-1:0]; res_c = sum[DW];
                        res_v = (acc_q[DW-1] == operand[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
                    end
                    OP_SUB: begin
                        wr = 1'b1; res = diff[DW-1:0]; res_c = diff[DW];
                        res_v = (acc_q[DW-1] != operand[DW-1]) && (diff[DW-1] != acc_q[DW-1]);
                    end
                    OP_AND:  begin wr = 1'b1; res = acc_q & operand; end
                    OP_OR:   begin wr = 1'b1; res = acc_q | operand; end
                    OP_XOR:  begin wr = 1'b1; res = acc_q ^ operand; end
                    OP_SHL:  begin wr = 1'b1; res = {acc_q[DW-2:0], 1'b0}; res_c = acc_q[DW-1]; end
                    OP_SHR:  begin wr = 1'b1; res = {1'b0, acc_q[DW-1:1]}; res_c = acc_q[0]; end
                    OP_LDA:  begin wr = 1'b1; res = operand; end
                    OP_STA:  rf_we = 1'b1;
                    OP_JMP:  npc_calc = AW'(data_q);
                    OP_JZ:   if (zero_q) npc_calc = AW'(data_q);
                    OP_JC:   if (cout_q) npc_calc = AW'(data_q);
                    OP_RETI: begin npc_calc = saved_pc_q; int_en_d = 1'b1; end
                    OP_EI:   int_en_d = 1'b1;
                    OP_DI:   int_en_d = 1'b0;
                    default: ;
                endcase
                if (wr) begin
                    acc_d  = res;
                    cout_d = res_c;
                    ovf_d  = res_v;
                    zero_d = (res == '0);
                end
                // The interrupted instruction still retires; its successor PC becomes the return point.
                if (take_int) begin
                    saved_pc_d = npc_calc;
                    npc_calc   = InteruptAdrReg;
                    int_en_d   = 1'b0;
                end
                if (op_q == OP_MUL) begin
                    pend_npc_d = npc_calc;
                    pend_ack_d = take_int;
                    mul_a_d    = {{DW{1'b0}}, acc_q};
                    mul_b_d    = operand;
                    prod_d     = '0;
                    cnt_d      = '0;
                    state_d    = MUL;
                end else begin
                    npc_d     = npc_calc;
                    int_ack_d = take_int;
                    state_d   = DONE;
                end
            end
            MUL: begin
                prod_d  = mul_sum;
                mul_a_d = mul_a_q << 1;
                mul_b_d = mul_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    acc_d     = mul_sum[DW-1:0];
                    cout_d    = |mul_sum[2*DW-1:DW];
                    zero_d    = (mul_sum[DW-1:0] == '0);
                    ovf_d     = 1'b0;
                    npc_d     = pend_npc_q;
                    int_ack_d = pend_ack_q;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            mode_q     <= '0;
            data_q     <= '0;
            pc_q       <= '0;
            acc_q      <= '0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            npc_q      <= '0;
            saved_pc_q <= '0;
            pend_npc_q <= '0;
            pend_ack_q <= 1'b0;
            int_en_q   <= 1'b1;
            int_ack_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            npc_q      <= npc_d;
            saved_pc_q <= saved_pc_d;
            pend_npc_q <= pend_npc_d;
            pend_ack_q <= pend_ack_d;
            int_en_q   <= int_en_d;
            int_ack_q  <= int_ack_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
            if (rf_we) rf_q[rf_idx] <= acc_q;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign StageComplete  = (state_q == DONE);
    assign int_ack        = int_ack_q;
    assign ACCout         = acc_q;
    assign coutRegout     = cout_q;
    assign zeroRegout     = zero_q;
    assign overflowRegout = ovf_q;
    assign NextPctr       = npc_q;
endmodule

// File: tb/tb_acc_exec_stage.sv
// Scoreboard bench for acc_exec_stage: default 8-bit build plus a DW=16/AW=12 build.
module tb_acc_exec_stage;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0, nbad = 0;

    typedef struct {
        logic [31:0] acc;
        logic        c, z, v;
        logic [31:0] npc;
        logic        ack;
        int          cyc;
        int          lat;
    } exp_t;
    exp_t q1[$], q2[$];
    exp_t e1, e2;

    // 8-bit build
    logic [4:0] instr = '0; logic [2:0] mode = '0; logic [7:0] data = '0, pc = '0, vec = 8'h09;
    logic in_valid = 1'b0, int_req = 1'b0, in_ready;
    logic [7:0] acc, npc; logic cout, zero, ovf, done, ack;

    acc_exec_stage u_d8 (
        .clk(clk), .reset(reset), .StageRegInstr_out(instr), .StageRegAddrMode_out(mode),
        .StageRegData_out(data), .StageRegPCtr_out(pc), .in_valid(in_valid), .in_ready(in_ready),
        .InteruptAdrReg(vec), .int_req(int_req), .ACCout(acc), .coutRegout(cout),
        .zeroRegout(zero), .overflowRegout(ovf), .NextPctr(npc), .StageComplete(done),
        .int_ack(ack));

    // 16-bit data / 12-bit PC build
    logic [4:0] b_instr = '0; logic [2:0] b_mode = '0; logic [15:0] b_data = '0;
    logic [11:0] b_pc = '0, b_vec = '0;
    logic b_in_valid = 1'b0, b_int_req = 1'b0, b_in_ready;
    logic [15:0] b_acc; logic [11:0] b_npc; logic b_cout, b_zero, b_ovf, b_done, b_ack;

    acc_exec_stage #(.DW(16), .AW(12), .RF_DEPTH(16)) u_d16 (
        .clk(clk), .reset(reset), .StageRegInstr_out(b_instr), .StageRegAddrMode_out(b_mode),
        .StageRegData_out(b_data), .StageRegPCtr_out(b_pc), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .InteruptAdrReg(b_vec), .int_req(b_int_req), .ACCout(b_acc),
        .coutRegout(b_cout), .zeroRegout(b_zero), .overflowRegout(b_ovf), .NextPctr(b_npc),
        .StageComplete(b_done), .int_ack(b_ack));

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic bad(input string nm);
        ncmp++; nbad++;
        $display("FAIL %s got=event exp=none", nm);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (q1.size() == 0) bad("d8_unexpected_complete");
            else begin
                e1 = q1.pop_front();
                cmp("d8_acc", 32'(acc), e1.acc);
                cmp("d8_cout", 32'(cout), 32'(e1.c));
                cmp("d8_zero", 32'(zero), 32'(e1.z));
                cmp("d8_ovf", 32'(ovf), 32'(e1.v));
                cmp("d8_npc", 32'(npc), e1.npc);
                cmp("d8_ack", 32'(ack), 32'(e1.ack));
                cmp("d8_latency", 32'(cyc - e1.cyc), 32'(e1.lat));
            end
        end else if (!reset && ack) bad("d8_ack_without_complete");
    end

    always @(negedge clk) begin
        if (!reset && b_done) begin
            if (q2.size() == 0) bad("d16_unexpected_complete");
            else begin
                e2 = q2.pop_front();
                cmp("d16_acc", 32'(b_acc), e2.acc);
                cmp("d16_cout", 32'(b_cout), 32'(e2.c));
                cmp("d16_zero", 32'(b_zero), 32'(e2.z));
                cmp("d16_ovf", 32'(b_ovf), 32'(e2.v));
                cmp("d16_npc", 32'(b_npc), e2.npc);
                cmp("d16_ack", 32'(b_ack), 32'(e2.ack));
                cmp("d16_latency", 32'(cyc - e2.cyc), 32'(e2.lat));
            end
        end
    end

    task automatic issue1(input logic [4:0] op, input logic [2:0] md, input logic [7:0] d,
                          input logic [7:0] p, input bit push, input logic [7:0] eacc,
                          input bit ec, input bit ez, input bit ev, input logic [7:0] enpc,
                          input bit eack, input int lat);
        exp_t e;
        int n = 0;
        @(negedge clk);
        instr = op; mode = md; data = d; pc = p; in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) bad("d8_in_ready_timeout");
        e.acc = 32'(eacc); e.c = ec; e.z = ez; e.v = ev; e.npc = 32'(enpc); e.ack = eack;
        e.cyc = cyc; e.lat = lat;
        if (push) q1.push_back(e);
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic issue2(input logic [4:0] op, input logic [15:0] d, input logic [11:0] p,
                          input logic [15:0] eacc, input bit ec, input bit ez, input bit ev,
                          input logic [11:0] enpc, input int lat);
        exp_t e;
        int n = 0;
        @(negedge clk);
        b_instr = op; b_mode = 3'b000; b_data = d; b_pc = p; b_in_valid = 1'b1;
        while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) bad("d16_in_ready_timeout");
        e.acc = 32'(eacc); e.c = ec; e.z = ez; e.v = ev; e.npc = 32'(enpc); e.ack = 1'b0;
        e.cyc = cyc; e.lat = lat;
        q2.push_back(e);
        @(posedge clk); #1 b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) bad("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cmp("rst_acc", 32'(acc), 0);
        cmp("rst_flags", {29'd0, cout, zero, ovf}, 0);
        cmp("rst_npc", 32'(npc), 0);
        cmp("rst_ready", 32'(in_ready), 1);
        cmp("rst_done_ack", {30'd0, done, ack}, 0);
        cmp("rst_d16_acc", 32'(b_acc), 0);

        //     op     mode  data   pc     push acc    c  z  v  npc    ack lat
        issue1(5'h08, 3'd0, 8'h04, 8'h06, 1, 8'h04, 0, 0, 0, 8'h07, 0, 2);   // LDA 4
        issue1(5'h08, 3'd0, 8'h7F, 8'h00, 1, 8'h7F, 0, 0, 0, 8'h01, 0, 2);   // LDA 7F
        issue1(5'h01, 3'd0, 8'h01, 8'h01, 1, 8'h80, 0, 0, 1, 8'h02, 0, 2);   // ADD 1 -> ovf
        issue1(5'h01, 3'd0, 8'h80, 8'h02, 1, 8'h00, 1, 1, 1, 8'h03, 0, 2);   // ADD 80 -> carry
        issue1(5'h08, 3'd0, 8'h80, 8'h03, 1, 8'h80, 0, 0, 0, 8'h04, 0, 2);   // LDA 80
        issue1(5'h09, 3'd0, 8'h03, 8'h04, 1, 8'h80, 0, 0, 0, 8'h05, 0, 2);   // STA rf[3]
        issue1(5'h08, 3'd0, 8'h00, 8'h05, 1, 8'h00, 0, 1, 0, 8'h06, 0, 2);   // LDA 0
        issue1(5'h01, 3'd1, 8'h03, 8'h06, 1, 8'h80, 0, 0, 0, 8'h07, 0, 2);   // ADD rf[3]
        issue1(5'h0B, 3'd0, 8'h20, 8'h07, 1, 8'h80, 0, 0, 0, 8'h08, 0, 2);   // JZ not taken
        issue1(5'h02, 3'd0, 8'h81, 8'h08, 1, 8'hFF, 1, 0, 0, 8'h09, 0, 2);   // SUB borrow
        issue1(5'h0C, 3'd0, 8'h20, 8'h09, 1, 8'hFF, 1, 0, 0, 8'h20, 0, 2);   // JC taken
        issue1(5'h07, 3'd0, 8'h00, 8'h20, 1, 8'h7F, 1, 0, 0, 8'h21, 0, 2);   // SHR
        issue1(5'h05, 3'd0, 8'h7F, 8'h21, 1, 8'h00, 0, 1, 0, 8'h22, 0, 2);   // XOR -> 0
        issue1(5'h0B, 3'd0, 8'h40, 8'h22, 1, 8'h00, 0, 1, 0, 8'h40, 0, 2);   // JZ taken
        issue1(5'h08, 3'd0, 8'h81, 8'h40, 1, 8'h81, 0, 0, 0, 8'h41, 0, 2);   // LDA 81
        issue1(5'h06, 3'd0, 8'h00, 8'h41, 1, 8'h02, 1, 0, 0, 8'h42, 0, 2);   // SHL
        issue1(5'h1F, 3'd0, 8'h55, 8'hFF, 1, 8'h02, 1, 0, 0, 8'h00, 0, 2);   // unknown op, PC wrap
        issue1(5'h08, 3'd0, 8'h0C, 8'h40, 1, 8'h0C, 0, 0, 0, 8'h41, 0, 2);   // LDA 0C
        issue1(5'h0D, 3'd0, 8'h15, 8'h41, 1, 8'hFC, 0, 0, 0, 8'h42, 0, 10);  // MUL 0C*15
        issue1(5'h08, 3'd0, 8'h10, 8'h42, 1, 8'h10, 0, 0, 0, 8'h43, 0, 2);   // LDA 10
        issue1(5'h0D, 3'd0, 8'h10, 8'h43, 1, 8'h00, 1, 1, 0, 8'h44, 0, 10);  // MUL 10*10

        issue1(5'h08, 3'd0, 8'h05, 8'h05, 1, 8'h05, 0, 0, 0, 8'h06, 0, 2);   // LDA 5
        drain();
        int_req = 1'b1;
        issue1(5'h01, 3'd0, 8'h03, 8'h06, 1, 8'h08, 0, 0, 0, 8'h09, 1, 2);   // ADD, interrupt taken
        issue1(5'h00, 3'd0, 8'h00, 8'h09, 1, 8'h08, 0, 0, 0, 8'h0A, 0, 2);   // second request ignored
        drain();
        int_req = 1'b0;
        issue1(5'h0E, 3'd0, 8'h00, 8'h0A, 1, 8'h08, 0, 0, 0, 8'h07, 0, 2);   // RETI
        drain();
        int_req = 1'b1;
        issue1(5'h00, 3'd0, 8'h00, 8'h07, 1, 8'h08, 0, 0, 0, 8'h09, 1, 2);   // re-enabled
        drain();
        int_req = 1'b0;

        issue2(5'h08, 16'hFFFF, 12'hFFF, 16'hFFFF, 0, 0, 0, 12'h000, 2);     // LDA, PC wrap
        issue2(5'h01, 16'h0001, 12'h005, 16'h0000, 1, 1, 0, 12'h006, 2);     // FFFF+1
        issue2(5'h08, 16'h0100, 12'h006, 16'h0100, 0, 0, 0, 12'h007, 2);
        issue2(5'h0D, 16'h0100, 12'h007, 16'h0000, 1, 1, 0, 12'h008, 18);    // MUL overflow
        drain();

        issue1(5'h08, 3'd0, 8'h03, 8'h10, 1, 8'h03, 0, 0, 0, 8'h11, 0, 2);
        issue1(5'h0D, 3'd0, 8'h07, 8'h11, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);   // aborted by reset
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("abort_acc", 32'(acc), 0);
        cmp("abort_ready", 32'(in_ready), 1);
        cmp("abort_npc", 32'(npc), 0);
        cmp("abort_done", 32'(done), 0);
        repeat (15) @(negedge clk);
        cmp("abort_queue_empty", 32'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
